// File: rtl/ls_sequencer.sv
// Multicycle load/store sequencer between the main control FSM and data memory.
// Sub-word stores are read-modify-write; all outputs are registered from next state.
module ls_sequencer #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mdr_load_o,
  output logic [1:0]  ls_ctrl_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, CAPTURE, MERGE, WRITE, DONE, ERR
  } state_t;

  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] sd_q, sd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mdr_load_q, mdr_load_d;
  logic [1:0]  ls_ctrl_q, ls_ctrl_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bad_req;

  // op[1:0] encodes width for both loads and stores; 11 is the illegal code.
  assign bad_req = (op_i[1:0] == 2'b11)
                || (op_i[1:0] == 2'b00 && addr_i[1:0] != 2'b00)
                || (op_i[1:0] == 2'b01 && addr_i[0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sd_d        = sd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ls_ctrl_d   = ls_ctrl_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d       = op_i;
          sd_d       = store_data_i;
          mem_addr_d = addr_i;
          if (bad_req) begin
            state_d = ERR;
          end else if (op_i == OP_SW) begin
            state_d     = WRITE;
            mem_wdata_d = store_data_i;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) state_d = op_q[2] ? MERGE : CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: state_d = DONE;
      MERGE: begin
        mem_wdata_d = (op_q == OP_SH) ? {mem_rdata_i[31:16], sd_q[15:0]}
                                      : {mem_rdata_i[31:8],  sd_q[7:0]};
        state_d     = WRITE;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Moore outputs are registered off the state being entered.
    mem_wr_d   = (state_d == WRITE);
    mdr_load_d = (state_d == CAPTURE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    if (state_d == CAPTURE) begin
      ls_ctrl_d = (op_q == OP_LH) ? 2'b01 : (op_q == OP_LB) ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 3'b000;
      sd_q        <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wr_q    <= 1'b0;
      mdr_load_q  <= 1'b0;
      ls_ctrl_q   <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sd_q        <= sd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mdr_load_q  <= mdr_load_d;
      ls_ctrl_q   <= ls_ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mdr_load_o  = mdr_load_q;
  assign ls_ctrl_o   = ls_ctrl_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
